// File: rtl/mmio_timer_gpio_resp.sv
// Memory-mapped GPIO and compare-timer responder on the core data port.
// Every accepted request gets a one-cycle resp_valid/resp_data reply on the following cycle.
module mmio_timer_gpio_resp #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic              req_fcn,
    input  logic [2:0]        req_typ,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    logic              ready_q;
    logic [GPIO_W-1:0] gpio_s1, gpio_s2;
    logic [31:0]       cnt_q, cmp_q;
    logic [2:0]        ctrl_q;
    logic              match_q;

    logic        accept, hit, wr;
    logic [2:0]  sel;
    logic [1:0]  ofs;
    logic [4:0]  shift;
    logic [3:0]  be;
    logic [31:0] bitmask, wdata_sh, rd_word, rd_sh, rd_ext, gpio_word;
    logic        match_evt, status_clr;

    assign req_ready = ready_q;
    assign irq       = match_q & ctrl_q[1];
    assign accept    = req_valid & ready_q;
    // Only the first 32 bytes of the window hold registers; the rest reads as zero.
    assign hit       = (req_addr[31:8] == BASE_ADDR[31:8]) && (req_addr[7:5] == 3'd0);
    assign sel       = req_addr[4:2];
    assign wr        = accept & req_fcn & hit;
    assign match_evt = ctrl_q[0] && (cnt_q == cmp_q);

    always_comb begin
        gpio_word = '0;
        gpio_word[GPIO_W-1:0] = gpio_out;
        case (req_typ[1:0])
            2'd0:    ofs = req_addr[1:0];
            2'd1:    ofs = {req_addr[1], 1'b0};
            default: ofs = 2'd0;
        endcase
        case (req_typ[1:0])
            2'd0:    be = 4'b0001 << ofs;
            2'd1:    be = 4'b0011 << ofs;
            default: be = 4'b1111;
        endcase
        shift    = {ofs, 3'b000};
        bitmask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wdata_sh = req_data << shift;

        rd_word = '0;
        if (hit) begin
            case (sel)
                3'd0:    rd_word = gpio_word;
                3'd1:    rd_word[GPIO_W-1:0] = gpio_s2;
                3'd2:    rd_word = cnt_q;
                3'd3:    rd_word = cmp_q;
                3'd4:    rd_word[2:0] = ctrl_q;
                3'd5:    rd_word[0] = match_q;
                default: rd_word = '0;
            endcase
        end
        rd_sh = rd_word >> shift;
        case (req_typ[1:0])
            2'd0:    rd_ext = req_typ[2] ? {24'd0, rd_sh[7:0]} : {{24{rd_sh[7]}}, rd_sh[7:0]};
            2'd1:    rd_ext = req_typ[2] ? {16'd0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
            default: rd_ext = rd_sh;
        endcase
        status_clr = wr && (sel == 3'd5) && bitmask[0] && wdata_sh[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q    <= 1'b0;
            gpio_s1    <= '0;
            gpio_s2    <= '0;
            gpio_out   <= '0;
            cnt_q      <= '0;
            cmp_q      <= 32'hFFFF_FFFF;
            ctrl_q     <= '0;
            match_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            ready_q    <= 1'b1;
            gpio_s1    <= gpio_in;
            gpio_s2    <= gpio_s1;
            resp_valid <= accept;
            resp_data  <= (accept && !req_fcn) ? rd_ext : 32'd0;

            if (wr && sel == 3'd0)
                gpio_out <= (gpio_out & ~bitmask[GPIO_W-1:0]) | (wdata_sh[GPIO_W-1:0] & bitmask[GPIO_W-1:0]);
            if (wr && sel == 3'd3)
                cmp_q <= (cmp_q & ~bitmask) | (wdata_sh & bitmask);
            if (wr && sel == 3'd4)
                ctrl_q <= (ctrl_q & ~bitmask[2:0]) | (wdata_sh[2:0] & bitmask[2:0]);

            // Bus writes to the counter override both increment and auto-clear.
            if (wr && sel == 3'd2)
                cnt_q <= (cnt_q & ~bitmask) | (wdata_sh & bitmask);
            else if (ctrl_q[0])
                cnt_q <= (match_evt && ctrl_q[2]) ? 32'd0 : cnt_q + 32'd1;

            if (match_evt)
                match_q <= 1'b1;
            else if (status_clr)
                match_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_timer_gpio_resp.sv
// Directed bench for mmio_timer_gpio_resp: bus accesses, lane handling, timer, GPIO sync, reset.
module tb_mmio_timer_gpio_resp;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        req_fcn = 1'b0;
    logic [2:0]  req_typ = 3'd2;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mmio_timer_gpio_resp #(.BASE_ADDR(BASE), .GPIO_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .req_fcn(req_fcn), .req_typ(req_typ),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
    );

    always #5 clk = ~clk;

    // Called at a negedge; request is accepted at the next posedge, reply sampled at the following negedge.
    task automatic bus(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] data, output logic rv, output logic [31:0] rd);
        req_valid = 1'b1;
        req_fcn   = fcn;
        req_typ   = typ;
        req_addr  = addr;
        req_data  = data;
        @(negedge clk);
        rv = resp_valid;
        rd = resp_data;
        req_valid = 1'b0;
        req_fcn   = 1'b0;
    endtask

    task automatic test_reset();
        logic rv;
        logic [31:0] rd;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_data !== 32'd0) begin errors++; $display("FAIL reset_resp got %b/%h want 0/0", resp_valid, resp_data); end
        checks++; if (gpio_out !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL reset_out got gpio %h irq %b want 00/0", gpio_out, irq); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", req_ready); end
        bus(1'b0, 3'd2, BASE + 32'h0C, 32'd0, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp got %b/%h want 1/ffffffff", rv, rd); end
        bus(1'b0, 3'd2, BASE + 32'h08, 32'd0, rv, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h want 0", rd); end
    endtask

    task automatic test_gpio();
        logic rv;
        logic [31:0] rd;
        bus(1'b1, 3'd2, BASE, 32'h0000_00A5, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL sw_gpio_resp got %b/%h want 1/0", rv, rd); end
        checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL gpio_out got %h want a5", gpio_out); end
        bus(1'b0, 3'd2, BASE, 32'd0, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'h0000_00A5) begin errors++; $display("FAIL lw_gpio got %b/%h want 1/000000a5", rv, rd); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || resp_data !== 32'd0) begin errors++; $display("FAIL idle_resp got %b/%h want 0/0", resp_valid, resp_data); end
        gpio_in = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        bus(1'b0, 3'd2, BASE + 32'h04, 32'd0, rv, rd);
        checks++; if (rd !== 32'h0000_003C) begin errors++; $display("FAIL gpio_in got %h want 0000003c", rd); end
        bus(1'b0, 3'd0, BASE + 32'h04, 32'd0, rv, rd);
        checks++; if (rd !== 32'h0000_003C) begin errors++; $display("FAIL gpio_in_lb got %h want 0000003c", rd); end
    endtask

    task automatic test_lanes();
        logic rv;
        logic [31:0] rd;
        bus(1'b1, 3'd2, BASE + 32'h0C, 32'h1234_80FF, rv, rd);
        bus(1'b0, 3'd0, BASE + 32'h0C, 32'd0, rv, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lb_0c got %h want ffffffff", rd); end
        bus(1'b0, 3'd4, BASE + 32'h0D, 32'd0, rv, rd);
        checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_0d got %h want 00000080", rd); end
        bus(1'b0, 3'd1, BASE + 32'h0E, 32'd0, rv, rd);
        checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL lh_0e got %h want 00001234", rd); end
        bus(1'b0, 3'd5, BASE + 32'h0C, 32'd0, rv, rd);
        checks++; if (rd !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_0c got %h want 000080ff", rd); end
        bus(1'b0, 3'd1, BASE + 32'h0D, 32'd0, rv, rd);
        checks++; if (rd !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_0d got %h want ffff80ff", rd); end
        bus(1'b1, 3'd0, BASE + 32'h0E, 32'h0000_0077, rv, rd);
        bus(1'b0, 3'd2, BASE + 32'h0C, 32'd0, rv, rd);
        checks++; if (rd !== 32'h1277_80FF) begin errors++; $display("FAIL sb_0e got %h want 127780ff", rd); end
        bus(1'b1, 3'd1, BASE + 32'h0F, 32'h0000_ABCD, rv, rd);
        bus(1'b0, 3'd2, BASE + 32'h0C, 32'd0, rv, rd);
        checks++; if (rd !== 32'hABCD_80FF) begin errors++; $display("FAIL sh_0e got %h want abcd80ff", rd); end
    endtask

    task automatic test_timer_match();
        logic rv;
        logic [31:0] rd;
        int found;
        bus(1'b1, 3'd2, BASE + 32'h0C, 32'd5, rv, rd);
        bus(1'b1, 3'd2, BASE + 32'h08, 32'd0, rv, rd);
        bus(1'b1, 3'd2, BASE + 32'h10, 32'd7, rv, rd);
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (irq === 1'b1) begin found = k; break; end
        end
        checks++; if (found != 6) begin errors++; $display("FAIL irq_rise_cycle got %0d want 6", found); end
        bus(1'b0, 3'd2, BASE + 32'h08, 32'd0, rv, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL cnt_autoclr got %h want 0", rd); end
        bus(1'b0, 3'd2, BASE + 32'h14, 32'd0, rv, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL status_match got %h want 1", rd); end
        bus(1'b1, 3'd2, BASE + 32'h14, 32'd1, rv, rd);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b want 0", irq); end
        @(negedge clk);
        @(negedge clk);
        bus(1'b1, 3'd2, BASE + 32'h14, 32'd1, rv, rd);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %b want 1", irq); end
        bus(1'b1, 3'd2, BASE + 32'h10, 32'd0, rv, rd);
        bus(1'b0, 3'd2, BASE + 32'h14, 32'd0, rv, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL status_sticky got %h want 1", rd); end
        bus(1'b1, 3'd2, BASE + 32'h14, 32'd1, rv, rd);
        bus(1'b0, 3'd2, BASE + 32'h14, 32'd0, rv, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL status_cleared got %h want 0", rd); end
    endtask

    task automatic test_timer_wrap();
        logic rv;
        logic [31:0] rd;
        bus(1'b1, 3'd2, BASE + 32'h0C, 32'h10, rv, rd);
        bus(1'b1, 3'd2, BASE + 32'h08, 32'hFFFF_FFFE, rv, rd);
        bus(1'b1, 3'd2, BASE + 32'h10, 32'd1, rv, rd);
        @(negedge clk);
        bus(1'b0, 3'd2, BASE + 32'h08, 32'd0, rv, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre got %h want ffffffff", rd); end
        bus(1'b0, 3'd2, BASE + 32'h08, 32'd0, rv, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL wrap_zero got %h want 0", rd); end
        bus(1'b1, 3'd2, BASE + 32'h10, 32'd0, rv, rd);
        bus(1'b0, 3'd2, BASE + 32'h14, 32'd0, rv, rd);
        checks++; if (rd !== 32'd0 || irq !== 1'b0) begin errors++; $display("FAIL wrap_nomatch got %h/%b want 0/0", rd, irq); end
    endtask

    task automatic test_back_to_back();
        logic rv1, rv2, rv3;
        logic [31:0] rd1, rd2, rd3;
        bus(1'b1, 3'd0, BASE, 32'h11, rv1, rd1);
        bus(1'b1, 3'd0, BASE, 32'h22, rv2, rd2);
        bus(1'b0, 3'd4, BASE, 32'd0, rv3, rd3);
        checks++; if ({rv1, rv2, rv3} !== 3'b111) begin errors++; $display("FAIL b2b_valid got %b want 111", {rv1, rv2, rv3}); end
        checks++; if (rd3 !== 32'h22 || gpio_out !== 8'h22) begin errors++; $display("FAIL b2b_data got %h/%h want 22/22", rd3, gpio_out); end
    endtask

    task automatic test_undecoded();
        logic rv;
        logic [31:0] rd;
        bus(1'b1, 3'd2, BASE + 32'h100, 32'hFF, rv, rd);
        checks++; if (rv !== 1'b1 || gpio_out !== 8'h22) begin errors++; $display("FAIL miss_write got %b/%h want 1/22", rv, gpio_out); end
        bus(1'b0, 3'd2, BASE + 32'h100, 32'd0, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL miss_read got %b/%h want 1/0", rv, rd); end
        bus(1'b0, 3'd2, BASE + 32'h18, 32'd0, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL undec_read got %b/%h want 1/0", rv, rd); end
    endtask

    task automatic test_mid_reset();
        logic rv;
        logic [31:0] rd;
        bus(1'b1, 3'd2, BASE + 32'h10, 32'd2, rv, rd);
        req_valid = 1'b1;
        req_fcn   = 1'b0;
        req_typ   = 3'd2;
        req_addr  = BASE;
        rst       = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b0 || resp_data !== 32'd0) begin errors++; $display("FAIL rst_drop got %b/%h want 0/0", resp_valid, resp_data); end
        checks++; if (req_ready !== 1'b0 || gpio_out !== 8'h00) begin errors++; $display("FAIL rst_state got %b/%h want 0/00", req_ready, gpio_out); end
        rst = 1'b0;
        @(negedge clk);
        bus(1'b0, 3'd2, BASE + 32'h10, 32'd0, rv, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_ctrl got %h want 0", rd); end
        bus(1'b0, 3'd2, BASE + 32'h0C, 32'd0, rv, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp got %h want ffffffff", rd); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_gpio();
        test_lanes();
        test_timer_match();
        test_timer_wrap();
        test_back_to_back();
        test_undecoded();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_timer_gpio_resp.md
# mmio_timer_gpio_resp

Memory-mapped peripheral responder for the data-memory port protocol the core drives: it answers valid/addr/data/fcn/typ requests with a one-cycle resp_valid/resp_data reply, just as the on-chip memory does. It holds a GPIO output register, a synchronized GPIO input, and a 32-bit compare timer with a sticky match flag and interrupt. It sits beside the on-chip memory on the core's data port, selected by an upper-address decode.

## Interface
- BASE_ADDR, 32'h4000_0000: block base; decode is addr[31:8] == BASE_ADDR[31:8]
- GPIO_W, 8: GPIO width, 1..32
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  32  byte address
- req_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_fcn  in  1  1 = write, 0 = read
- req_typ  in  3  RISC-V func3: 0 B, 1 H, 2 W, 4 BU, 5 HU
- resp_valid  out  1  one-cycle response strobe, for reads and writes
- resp_data  out  32  read data, extended per typ; 0 for writes
- gpio_in  in  GPIO_W  asynchronous inputs
- gpio_out  out  GPIO_W  GPIO_OUT register
- irq  out  1  STATUS.MATCH & CTRL.IRQ_EN

## Operation
- Register map (addr[4:2]); undecoded offsets and non-matching bases read 0, ignore writes, and still respond:
  - 0x00 GPIO_OUT RW [GPIO_W-1:0]
  - 0x04 GPIO_IN RO, 2-flop synchronized gpio_in
  - 0x08 TIMER_CNT RW
  - 0x0C TIMER_CMP RW
  - 0x10 CTRL RW: bit0 EN, bit1 IRQ_EN, bit2 AUTO_CLR
  - 0x14 STATUS: bit0 MATCH, sticky, write-1-to-clear
- Accept = req_valid & req_ready. req_ready is 0 during reset and 1 afterwards.
- Lane select:
  - typ[1:0]=0 uses byte addr[1:0].
  - typ[1:0]=1 uses half addr[1]; addr[0] is ignored.
  - typ[1:0]=2 uses the full word; addr[1:0] are ignored.
  - typ[1:0]=3 is treated as a word.
- Reads: selected lane is shifted to bit 0, then sign-extended if typ[2]=0, else zero-extended.
- Writes: only selected-lane bytes are updated, merged with the current register value; typ[2] is ignored.
- Timer: when EN=1, each cycle TIMER_CNT increments and wraps 0xFFFF_FFFF -> 0.
  - If EN=1 and TIMER_CNT == TIMER_CMP at an edge, MATCH is set.
  - In that same case, if AUTO_CLR=1, TIMER_CNT loads 0 instead of incrementing.
- Simultaneous events:
  - A TIMER_CNT write wins over increment/auto-clear; a partial write merges with the pre-increment value.
  - MATCH set wins over a same-cycle W1C clear.
  - A CTRL write takes effect at the next edge.
- Reset values:
  - gpio_out=0, TIMER_CNT=0, TIMER_CMP=0xFFFF_FFFF, CTRL=0, MATCH=0
  - resp_valid=0, resp_data=0, irq=0, req_ready=0, sync flops=0

## Timing
- Request accepted at edge N:
  - resp_valid=1 during cycle N+1 for exactly one cycle.
  - resp_data is valid with resp_valid; it holds 0 otherwise.
- Read data is sampled at edge N, i.e. the value before any update made at that edge.
- Write effect is visible from cycle N+1, so a read accepted at edge N+1 returns the new value.
- Back-to-back accepts on consecutive edges give back-to-back resp_valid pulses; there is no stall.
- GPIO_IN latency: a gpio_in change is readable after 2 edges.
- irq is combinational from registered MATCH/IRQ_EN; it rises in the cycle after the matching edge.
- rst asserted mid-transaction: the pending response is dropped (resp_valid=0 next cycle) and all state returns to reset values.

## Test plan
- Reset, then SW 0xA5 to 0x00, then LW 0x00 → gpio_out=0xA5, resp_data=0x0000_00A5, resp_valid 1 cycle after each accept.
- SW 0x1234_80FF to TIMER_CMP (EN=0), then:
  - LB @0x0C → 0xFFFF_FFFF
  - LBU @0x0D → 0x0000_0080
  - LH @0x0E → 0x0000_1234
  - LHU @0x0C → 0x0000_80FF
- SB 0x77 @0x0E over CMP=0x1234_80FF → CMP=0x1277_80FF; the other bytes are unchanged.
- Timer sequence:
  - CMP=5, CTRL=0x7 → MATCH sets when CNT==5, CNT then reads 0, irq=1.
  - SW 1 to STATUS → MATCH=0, irq=0.
  - W1C in the same cycle as a match → MATCH stays 1.
- CNT=0xFFFF_FFFE, EN=1 → wraps to 0 after 2 cycles, with no match when CMP=0x10.
- Edge cases:
  - LW to BASE_ADDR+0x100 → resp 0 with resp_valid.
  - rst pulse between accept and response → no resp_valid, all registers at reset values.
